// File: rtl/sw_debounce_port_if.sv
// KCPSM6 I/O bus slice used by the switch port: read address/strobe, read data,
// and the interrupt request/acknowledge pair.
interface sw_debounce_port_if;
    logic [7:0] port_id;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    // Processor side drives address, strobe and acknowledge.
    modport master (
        output port_id,
        output read_strobe,
        output interrupt_ack,
        input  in_port,
        input  interrupt
    );

    // Peripheral side returns read data and raises the interrupt.
    modport slave (
        input  port_id,
        input  read_strobe,
        input  interrupt_ack,
        output in_port,
        output interrupt
    );
endinterface

// File: rtl/sw_debounce_port.sv
// Debounced switch input port for KCPSM6: 2-FF sync, per-bit stability counter,
// sticky change flags cleared on read, and a level interrupt cleared by acknowledge.
module sw_debounce_port #(
    parameter int         W         = 8,
    parameter int         DB_CYCLES = 1000000,
    parameter logic [7:0] SW_ADDR   = 8'h00,
    parameter logic [7:0] FLAG_ADDR = 8'h01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          sw,
    sw_debounce_port_if.slave     bus
);

    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } irq_state_e;

    logic [W-1:0]          sync1_q, sync2_q;
    logic [W-1:0]          stable_q, stable_d;
    logic [W-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]          flags_q, flags_d;
    logic [W-1:0]          flag_set;
    logic                  flag_clr;
    logic                  new_set;
    logic [7:0]            in_port_q, in_port_d;
    irq_state_e            state_q, state_d;
    logic                  irq;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: any sample that agrees with the accepted level
    // restarts the count, so only an unbroken run of DB_CYCLES is accepted.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        flag_set = '0;
        for (int i = 0; i < W; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                flag_set[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // A set in the same cycle as a read-clear survives; other bits clear.
    always_comb begin
        flag_clr = bus.read_strobe && (bus.port_id == FLAG_ADDR);
        flags_d  = flag_clr ? flag_set : (flags_q | flag_set);
        new_set  = |(flag_set & ~flags_q);
    end

    always_comb begin
        in_port_d = 8'h00;
        if (bus.port_id == SW_ADDR) begin
            in_port_d[W-1:0] = stable_q;
        end else if (bus.port_id == FLAG_ADDR) begin
            in_port_d[W-1:0] = flags_q;
        end
    end

    // NOTE: the per-bit counters are reset along with the rest so a reset
    // mid-debounce can never carry a partial count into the next run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q  <= '0;
            cnt_q     <= '0;
            flags_q   <= '0;
            in_port_q <= 8'h00;
        end else begin
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            in_port_q <= in_port_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only a fresh 0->1 flag raises the request; ack loses to a coincident new set.
    always_comb begin
        state_d = state_q;
        irq     = 1'b0;
        case (state_q)
            IDLE: begin
                if (new_set) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                irq = 1'b1;
                if (bus.interrupt_ack && !new_set) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_port   = in_port_q;
    assign bus.interrupt = irq;

endmodule

// File: tb/tb_sw_debounce_port.sv
// Directed bench for sw_debounce_port with DB_CYCLES=4, W=8; expected values are
// hand-derived from the debounce timing (accept on the 6th edge after a raw change).
module tb_sw_debounce_port;

    localparam logic [7:0] SW_ADDR   = 8'h00;
    localparam logic [7:0] FLAG_ADDR = 8'h01;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic [7:0] rd;

    int n_checks = 0;
    int n_pass   = 0;

    sw_debounce_port_if bus ();

    sw_debounce_port #(
        .W         (8),
        .DB_CYCLES (4),
        .SW_ADDR   (SW_ADDR),
        .FLAG_ADDR (FLAG_ADDR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_port(input logic [7:0] addr, output logic [7:0] data);
        bus.port_id     = addr;
        bus.read_strobe = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
        data            = bus.in_port;
    endtask

    task automatic ack_irq();
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        sw                = 8'hFF;
        bus.port_id       = SW_ADDR;
        bus.read_strobe   = 1'b0;
        bus.interrupt_ack = 1'b0;

        // 1: reset held with switches high, then release with switches low
        tick(5);
        check("rst_in_port", bus.in_port, 8'h00);
        check("rst_irq", {7'b0, bus.interrupt}, 8'h00);
        sw    = 8'h00;
        reset = 1'b1;
        tick(8);
        read_port(SW_ADDR, rd);   check("rel_sw", rd, 8'h00);
        read_port(FLAG_ADDR, rd); check("rel_flags", rd, 8'h00);
        check("rel_irq", {7'b0, bus.interrupt}, 8'h00);

        // 2: 00->05, accepted on edge 6, visible on in_port one edge later
        bus.port_id = SW_ADDR;
        sw = 8'h05;
        tick(6);
        check("sw_before_accept", bus.in_port, 8'h00);
        tick();
        check("sw_after_accept", bus.in_port, 8'h05);
        check("irq_on_change", {7'b0, bus.interrupt}, 8'h01);
        read_port(FLAG_ADDR, rd); check("flags_first_read", rd, 8'h05);
        read_port(FLAG_ADDR, rd); check("flags_cleared", rd, 8'h00);
        check("irq_survives_read", {7'b0, bus.interrupt}, 8'h01);
        ack_irq();
        check("irq_after_ack", {7'b0, bus.interrupt}, 8'h00);
        tick(3);
        check("irq_no_reraise", {7'b0, bus.interrupt}, 8'h00);

        // 3: bit0 bounces with 3-cycle phases, one short of acceptance
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) sw[0] = ~sw[0];
            tick();
        end
        sw = 8'h05;
        tick(8);
        read_port(SW_ADDR, rd);   check("bounce_sw", rd, 8'h05);
        read_port(FLAG_ADDR, rd); check("bounce_flags", rd, 8'h00);
        check("bounce_irq", {7'b0, bus.interrupt}, 8'h00);

        // 4: interrupt held through an ack that coincides with a new bit3 set
        sw = 8'h07;
        tick(8);
        check("irq_bit1", {7'b0, bus.interrupt}, 8'h01);
        sw = 8'h0F;
        tick(5);
        ack_irq();
        check("ack_vs_new_set", {7'b0, bus.interrupt}, 8'h01);
        tick();
        check("ack_vs_new_set_hold", {7'b0, bus.interrupt}, 8'h01);
        read_port(FLAG_ADDR, rd); check("flags_bit1_bit3", rd, 8'h0A);
        ack_irq();
        check("irq_cleared_2", {7'b0, bus.interrupt}, 8'h00);

        // 5: read-clear on the same edge bit2 is accepted
        sw = 8'h0E;
        tick(8);
        ack_irq();
        check("irq_cleared_3", {7'b0, bus.interrupt}, 8'h00);
        sw = 8'h0A;
        tick(5);
        read_port(FLAG_ADDR, rd); check("preclear_flags", rd, 8'h01);
        read_port(FLAG_ADDR, rd); check("set_wins_clear", rd, 8'h04);
        check("irq_bit2", {7'b0, bus.interrupt}, 8'h01);

        // 6: async reset with counter=2 and interrupt pending
        bus.port_id = SW_ADDR;
        sw = 8'h0B;
        tick(4);
        check("pre_reset_in_port", bus.in_port, 8'h0A);
        reset = 1'b0;
        #2;
        check("async_in_port", bus.in_port, 8'h00);
        check("async_irq", {7'b0, bus.interrupt}, 8'h00);
        sw = 8'h00;
        tick(2);
        reset = 1'b1;
        tick(10);
        read_port(SW_ADDR, rd);   check("post_reset_sw", rd, 8'h00);
        read_port(FLAG_ADDR, rd); check("post_reset_flags", rd, 8'h00);
        check("post_reset_irq", {7'b0, bus.interrupt}, 8'h00);
        sw = 8'h03;
        tick(8);
        check("post_reset_change_irq", {7'b0, bus.interrupt}, 8'h01);
        read_port(FLAG_ADDR, rd); check("post_reset_change_flags", rd, 8'h03);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
